// File: rtl/ssp_int_ctrl.sv
// SSP interrupt status/control: IMSC mask, sticky ROR/RT raw status, ICR clears, masked outputs.
// Optional receive-timeout counter and RT source enabled by defining SSP_RX_TIMEOUT_EN.
module ssp_int_ctrl #(
   parameter int unsigned TO_BITS  = 32,
   parameter int unsigned TO_CNT_W = 6
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       IMSCWr,
   input  logic [3:0] IMSCWData,
   input  logic       ICRWr,
   input  logic [1:0] ICRWData,
   input  logic       RxOverrun,
   input  logic       RxWordWr,
   input  logic       RxRead,
   input  logic       RxNotEmpty,
   input  logic       RxHalfFull,
   input  logic       TxHalfEmpty,
   input  logic       BitTick,
   output logic [3:0] IMSC,
   output logic [3:0] RIS,
   output logic [3:0] MIS,
   output logic       RORINTR,
   output logic       RTINTR,
   output logic       RXINTR,
   output logic       TXINTR,
   output logic       INTR
);

   logic ror_q, ror_d;
   logic rt;

   always_comb begin
      ror_d = ror_q;
      if (ICRWr && ICRWData[0]) ror_d = 1'b0;
      if (RxOverrun)            ror_d = 1'b1;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) ror_q <= 1'b0;
      else          ror_q <= ror_d;
   end

`ifdef SSP_RX_TIMEOUT_EN
   typedef enum logic [1:0] {TO_IDLE, TO_COUNT, TO_EXPIRED} to_state_e;

   localparam logic [TO_CNT_W-1:0] CNT_LAST = TO_CNT_W'(TO_BITS - 1);
   localparam logic [TO_CNT_W-1:0] CNT_SAT  = TO_CNT_W'(TO_BITS);

   logic [3:0]          imsc_q;
   to_state_e           state_q;
   logic [TO_CNT_W-1:0] cnt_q;
   logic                rt_q;
   logic                rt_clr;

   assign rt_clr = ICRWr & ICRWData[1];

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) imsc_q <= '0;
      else if (IMSCWr) imsc_q <= IMSCWData;
   end

   // Priority: FIFO activity, then empty FIFO, then expiry (beats a coincident clear), then clear, then tick.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= TO_IDLE;
         cnt_q   <= '0;
         rt_q    <= 1'b0;
      end else begin
         if (rt_clr) rt_q <= 1'b0;
         if (RxWordWr || RxRead) begin
            cnt_q   <= '0;
            state_q <= RxNotEmpty ? TO_COUNT : TO_IDLE;
         end else if (!RxNotEmpty) begin
            cnt_q   <= '0;
            state_q <= TO_IDLE;
         end else if (BitTick && state_q != TO_EXPIRED && cnt_q == CNT_LAST) begin
            rt_q    <= 1'b1;
            cnt_q   <= rt_clr ? '0 : CNT_SAT;
            state_q <= rt_clr ? TO_COUNT : TO_EXPIRED;
         end else if (rt_clr) begin
            cnt_q   <= '0;
            state_q <= TO_COUNT;
         end else if (BitTick && state_q != TO_EXPIRED) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= TO_COUNT;
         end else if (state_q == TO_IDLE) begin
            state_q <= TO_COUNT;
         end
      end
   end

   assign IMSC = imsc_q;
   assign rt   = rt_q;
`else
   logic [2:0] imsc_q;
   logic       unused_inputs;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) imsc_q <= '0;
      else if (IMSCWr) imsc_q <= {IMSCWData[3:2], IMSCWData[0]};
   end

   assign IMSC = {imsc_q[2:1], 1'b0, imsc_q[0]};
   assign rt   = 1'b0;
   assign unused_inputs = ^{BitTick, RxWordWr, RxRead, IMSCWData[1], ICRWData[1],
                            (TO_BITS < (1 << TO_CNT_W))};
`endif

   assign RIS     = {TxHalfEmpty, RxHalfFull, rt, ror_q};
   assign MIS     = RIS & IMSC;
   assign RORINTR = MIS[0];
   assign RTINTR  = MIS[1];
   assign RXINTR  = MIS[2];
   assign TXINTR  = MIS[3];
   assign INTR    = |MIS;

endmodule

// File: tb/tb_ssp_int_ctrl.sv
// Scoreboard bench for ssp_int_ctrl: driver queues expected RIS/MIS/IMSC, monitor compares on the falling edge.
module tb_ssp_int_ctrl;

`ifdef SSP_RX_TIMEOUT_EN
   localparam logic [3:0] RTB = 4'b0010;
   localparam logic [3:0] MSK = 4'hF;
`else
   localparam logic [3:0] RTB = 4'b0000;
   localparam logic [3:0] MSK = 4'hD;
`endif

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic       IMSCWr, ICRWr, RxOverrun, RxWordWr, RxRead;
   logic       RxNotEmpty, RxHalfFull, TxHalfEmpty, BitTick;
   logic [3:0] IMSCWData;
   logic [1:0] ICRWData;
   logic [3:0] IMSC, RIS, MIS;
   logic       RORINTR, RTINTR, RXINTR, TXINTR, INTR;

   typedef struct {
      string      name;
      logic [3:0] ris;
      logic [3:0] mis;
      logic [3:0] imsc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 PCLK = ~PCLK;

   ssp_int_ctrl #(.TO_BITS(32), .TO_CNT_W(6)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .IMSCWr(IMSCWr), .IMSCWData(IMSCWData),
      .ICRWr(ICRWr), .ICRWData(ICRWData),
      .RxOverrun(RxOverrun), .RxWordWr(RxWordWr), .RxRead(RxRead),
      .RxNotEmpty(RxNotEmpty), .RxHalfFull(RxHalfFull), .TxHalfEmpty(TxHalfEmpty),
      .BitTick(BitTick),
      .IMSC(IMSC), .RIS(RIS), .MIS(MIS),
      .RORINTR(RORINTR), .RTINTR(RTINTR), .RXINTR(RXINTR), .TXINTR(TXINTR),
      .INTR(INTR)
   );

   task automatic cmp(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s.%s: got %b expected %b (t=%0t)", nm, fld, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge PCLK);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.name, "RIS",  RIS,  e.ris);
            cmp(e.name, "MIS",  MIS,  e.mis);
            cmp(e.name, "IMSC", IMSC, e.imsc);
            cmp(e.name, "INTRS", {TXINTR, RXINTR, RTINTR, RORINTR}, e.mis);
            cmp(e.name, "INTR", {3'b000, INTR}, {3'b000, |e.mis});
         end
      end
   end

   // One clock edge; single-cycle pulses drop right after it.
   task automatic cyc();
      @(posedge PCLK);
      #1;
      IMSCWr = 1'b0; ICRWr = 1'b0; RxOverrun = 1'b0;
      RxWordWr = 1'b0; RxRead = 1'b0; BitTick = 1'b0;
   endtask

   task automatic ticks(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         BitTick = 1'b1;
         cyc();
      end
   endtask

   task automatic expect_st(input string nm, input logic [3:0] ris, input logic [3:0] mis,
                            input logic [3:0] imsc);
      exp_t e;
      e.name = nm; e.ris = ris; e.mis = mis; e.imsc = imsc;
      sb.push_back(e);
      @(negedge PCLK);
      #1;
   endtask

   task automatic wr_imsc(input logic [3:0] d);
      IMSCWr = 1'b1; IMSCWData = d;
   endtask

   task automatic wr_icr(input logic [1:0] d);
      ICRWr = 1'b1; ICRWData = d;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : driver
      PRESETn = 1'b0;
      IMSCWr = 1'b0; IMSCWData = '0; ICRWr = 1'b0; ICRWData = '0;
      RxOverrun = 1'b0; RxWordWr = 1'b0; RxRead = 1'b0; BitTick = 1'b0;
      RxNotEmpty = 1'b0; RxHalfFull = 1'b0; TxHalfEmpty = 1'b1;
      repeat (2) @(posedge PCLK);
      #1;
      expect_st("reset", 4'b1000, 4'b0000, 4'h0);
      PRESETn = 1'b1;
      cyc();

      wr_imsc(4'hF); cyc();
      expect_st("imsc_all", 4'b1000, 4'b1000, MSK);
      TxHalfEmpty = 1'b0; RxHalfFull = 1'b1; cyc();
      expect_st("rx_level", 4'b0100, 4'b0100, MSK);

      RxHalfFull = 1'b0; RxOverrun = 1'b1; cyc();
      expect_st("ror_set", 4'b0001, 4'b0001, MSK);
      wr_icr(2'b01); cyc();
      expect_st("ror_clr", 4'b0000, 4'b0000, MSK);
      RxOverrun = 1'b1; wr_icr(2'b01); cyc();
      expect_st("ror_set_wins", 4'b0001, 4'b0001, MSK);
      wr_icr(2'b10); cyc();
      expect_st("icr_rt_only", 4'b0001, 4'b0001, MSK);
      wr_imsc(4'h0); cyc();
      expect_st("ror_masked", 4'b0001, 4'b0000, 4'h0);
      wr_imsc(4'b0001); cyc();
      expect_st("ror_unmask", 4'b0001, 4'b0001, 4'b0001);
      wr_imsc(4'hF); wr_icr(2'b01); cyc();
      expect_st("remask_clr", 4'b0000, 4'b0000, MSK);

      RxNotEmpty = 1'b1; cyc();
      ticks(31);
      expect_st("rt_31", 4'b0000, 4'b0000, MSK);
      ticks(1);
      expect_st("rt_32", RTB, RTB, MSK);

      wr_icr(2'b10); cyc();
      expect_st("rt_clr", 4'b0000, 4'b0000, MSK);
      ticks(31);
      expect_st("rt_again_31", 4'b0000, 4'b0000, MSK);
      ticks(1);
      expect_st("rt_again", RTB, RTB, MSK);

      wr_icr(2'b10); cyc();
      ticks(31);
      RxRead = 1'b1; cyc();
      ticks(31);
      expect_st("rt_read_31", 4'b0000, 4'b0000, MSK);
      ticks(1);
      expect_st("rt_after_read", RTB, RTB, MSK);

      wr_icr(2'b10); cyc();
      ticks(31);
      BitTick = 1'b1; wr_icr(2'b10); cyc();
      expect_st("rt_set_wins", RTB, RTB, MSK);

      wr_icr(2'b10); cyc();
      ticks(31);
      RxWordWr = 1'b1; BitTick = 1'b1; cyc();
      ticks(31);
      expect_st("rt_wordwr_31", 4'b0000, 4'b0000, MSK);
      ticks(1);
      expect_st("rt_after_wordwr", RTB, RTB, MSK);

      wr_icr(2'b10); cyc();
      ticks(31);
      RxNotEmpty = 1'b0; cyc();
      RxNotEmpty = 1'b1; cyc();
      ticks(1);
      expect_st("rt_empty_restart", 4'b0000, 4'b0000, MSK);
      ticks(30);
      expect_st("rt_empty_31", 4'b0000, 4'b0000, MSK);
      ticks(1);
      expect_st("rt_after_empty", RTB, RTB, MSK);

      RxOverrun = 1'b1; cyc();
      PRESETn = 1'b0;
      expect_st("async_reset", 4'b0000, 4'b0000, 4'h0);
      PRESETn = 1'b1;
      cyc();
      ticks(31);
      expect_st("post_reset_31", 4'b0000, 4'b0000, 4'h0);
      ticks(1);
      expect_st("post_reset_32", RTB, 4'b0000, 4'h0);

      repeat (2) @(negedge PCLK);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
